// File: rtl/feeder_pkg.sv
// Shared types and default sizing for the dual-lane feeder.
package feeder_pkg;

    // Per-lane holding register occupancy.
    typedef enum logic {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } lane_state_e;

    localparam int DEF_DWIDTH    = 32;
    localparam int DEF_CNT_WIDTH = 16;

endpackage

// File: rtl/feeder_lane_reg.sv
// One lane of the feeder: a single-entry holding register plus its ready logic.
// A lane can take a new word when it is empty or when its current word is
// being issued this cycle; flush and reset always win.
module feeder_lane_reg
    import feeder_pkg::*;
#(
    parameter int DWIDTH = DEF_DWIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              issue,
    input  logic              in_valid,
    input  logic [DWIDTH-1:0] in_data,
    output logic              in_ready,
    output logic              held,
    output logic [DWIDTH-1:0] hold_data
);

    lane_state_e       state_q, state_d;
    logic [DWIDTH-1:0] data_q, data_d;
    logic              accept;

    assign in_ready  = !rst && !flush && (state_q == EMPTY || issue);
    assign accept    = in_valid && in_ready;
    assign held      = (state_q == HELD);
    assign hold_data = data_q;

    // Next state: flush clears, accept (re)loads, a bare issue drains the lane.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (flush) begin
            state_d = EMPTY;
            data_d  = '0;
        end else if (accept) begin
            state_d = HELD;
            data_d  = in_data;
        end else if (issue) begin
            state_d = EMPTY;
            data_d  = '0;
        end
    end

    // Holding register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/dual_lane_feeder.sv
// Dual-lane feeder: two single-entry lanes drained together into a
// dual-enqueue FIFO, oldest word on slot A.
// Optional statistics counters are built when FEEDER_STATS_EN is defined;
// otherwise the counter outputs are tied to zero.
module dual_lane_feeder
    import feeder_pkg::*;
#(
    parameter int DWIDTH    = DEF_DWIDTH,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s0_valid,
    input  logic [DWIDTH-1:0]    s0_data,
    output logic                 s0_ready,
    input  logic                 s1_valid,
    input  logic [DWIDTH-1:0]    s1_data,
    output logic                 s1_ready,
    input  logic                 flush,
    input  logic                 fifo_in_valid,
    output logic                 inA_enque_en,
    output logic [DWIDTH-1:0]    inA_data,
    output logic                 inB_enque_en,
    output logic [DWIDTH-1:0]    inB_data,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] acc0_cnt,
    output logic [CNT_WIDTH-1:0] acc1_cnt
);

    logic              held0, held1, issue;
    logic [DWIDTH-1:0] data0, data1;
    logic              keep0, keep1;
    // age_q = 1 means lane 1 holds the older word.
    logic              age_q, age_d;

    assign issue = fifo_in_valid && (held0 || held1) && !flush;
    assign keep0 = held0 && !issue && !flush;
    assign keep1 = held1 && !issue && !flush;

    feeder_lane_reg #(.DWIDTH(DWIDTH)) u_lane0 (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .issue     (issue),
        .in_valid  (s0_valid),
        .in_data   (s0_data),
        .in_ready  (s0_ready),
        .held      (held0),
        .hold_data (data0)
    );

    feeder_lane_reg #(.DWIDTH(DWIDTH)) u_lane1 (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .issue     (issue),
        .in_valid  (s1_valid),
        .in_data   (s1_data),
        .in_ready  (s1_ready),
        .held      (held1),
        .hold_data (data1)
    );

    // Age: a retained word is older than anything loaded alongside it; fresh ties rank lane 0 first.
    always_comb begin
        age_d = age_q;
        if (keep0 && keep1) begin
            age_d = age_q;
        end else if (keep1) begin
            age_d = 1'b1;
        end else begin
            age_d = 1'b0;
        end
    end

    // Age flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            age_q <= 1'b0;
        end else begin
            age_q <= age_d;
        end
    end

    // Enqueue slot steering: oldest word on A, younger on B, zeros when idle.
    always_comb begin
        inA_enque_en = 1'b0;
        inB_enque_en = 1'b0;
        inA_data     = '0;
        inB_data     = '0;
        if (issue) begin
            if (held0 && held1) begin
                inA_enque_en = 1'b1;
                inB_enque_en = 1'b1;
                inA_data     = age_q ? data1 : data0;
                inB_data     = age_q ? data0 : data1;
            end else begin
                inA_enque_en = 1'b1;
                inA_data     = held0 ? data0 : data1;
            end
        end
    end

`ifdef FEEDER_STATS_EN
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] acc0_cnt_q, acc0_cnt_d;
    logic [CNT_WIDTH-1:0] acc1_cnt_q, acc1_cnt_d;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Saturating statistics: stalled cycles and per-lane accepts.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        acc0_cnt_d  = acc0_cnt_q;
        acc1_cnt_d  = acc1_cnt_q;
        if ((held0 || held1) && !fifo_in_valid) stall_cnt_d = sat_inc(stall_cnt_q);
        if (s0_valid && s0_ready) acc0_cnt_d = sat_inc(acc0_cnt_q);
        if (s1_valid && s1_ready) acc1_cnt_d = sat_inc(acc1_cnt_q);
    end

    // Statistics counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            acc0_cnt_q  <= '0;
            acc1_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            acc0_cnt_q  <= acc0_cnt_d;
            acc1_cnt_q  <= acc1_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign acc0_cnt  = acc0_cnt_q;
    assign acc1_cnt  = acc1_cnt_q;
`else
    assign stall_cnt = '0;
    assign acc0_cnt  = '0;
    assign acc1_cnt  = '0;
`endif

endmodule

// File: doc/dual_lane_feeder.md
DUAL_LANE_FEEDER -- requirements
Module: dual_lane_feeder

Interface
REQ-001 The module SHALL have parameter DWIDTH, default 32, which sets the data word width.
REQ-002 The module SHALL have parameter CNT_WIDTH, default 16, which sets the statistics counter width.
REQ-003 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 s0_valid / s0_data  input  1 / DWIDTH  lane-0 source word offered.
REQ-006 s0_ready  output  1  lane-0 word accepted this cycle when s0_valid is also high.
REQ-007 s1_valid / s1_data / s1_ready  in / in / out  1 / DWIDTH / 1  lane-1 equivalent of REQ-005 and REQ-006.
REQ-008 flush  input  1  synchronous discard of all held words.
REQ-009 fifo_in_valid  input  1  downstream dual-enqueue FIFO can take two words this cycle.
REQ-010 inA_enque_en / inA_data  output  1 / DWIDTH  first-ordered enqueue slot to the FIFO.
REQ-011 inB_enque_en / inB_data  output  1 / DWIDTH  second-ordered enqueue slot to the FIFO.
REQ-012 stall_cnt, acc0_cnt, acc1_cnt  output  CNT_WIDTH each  statistics counters (REQ-027).

Function
REQ-013 Each lane SHALL own a one-entry holding register with two states: EMPTY and HELD.
REQ-014 Lane state transitions SHALL be:
  - EMPTY->HELD on accept;
  - HELD->EMPTY on issue without accept;
  - HELD->HELD on issue plus accept in the same cycle, or on no issue;
  - any->EMPTY on flush.
REQ-015 sN_ready SHALL equal !flush & (stateN==EMPTY | issue), and SHALL be combinational from state, flush and fifo_in_valid only.
REQ-016 issue SHALL equal fifo_in_valid & (state0==HELD | state1==HELD) & !flush.
REQ-017 Latency SHALL be one cycle: a word accepted in cycle t appears on an enqueue port in cycle t+1 at the earliest.
REQ-018 On issue with one lane HELD, its word SHALL drive inA; inA_enque_en SHALL be 1 and inB_enque_en SHALL be 0.
REQ-019 On issue with both lanes HELD, the older word SHALL drive inA and the younger inB, with both enables at 1.
REQ-020 A 1-bit age flag SHALL record which lane was loaded first; words captured in the same cycle SHALL rank lane 0 as older.
REQ-021 When not issuing, both enables SHALL be 0 and inA_data/inB_data SHALL be 0.
REQ-022 While fifo_in_valid=0, HELD words SHALL be retained unchanged and ready SHALL follow REQ-015.
REQ-023 Flush SHALL take priority over accept and issue in the same cycle; no enable SHALL assert in a flush cycle.

Reset
REQ-024 rst SHALL force both lanes EMPTY, age flag 0, holding data 0 and all counters 0.
REQ-025 During reset, sN_ready, inA_enque_en and inB_enque_en SHALL be 0.
REQ-026 Reset asserted mid-transfer SHALL drop held words with no enqueue strobe emitted.

Configuration
REQ-027 Macro FEEDER_STATS_EN defined: stall_cnt SHALL count cycles with any lane HELD and fifo_in_valid=0; acc0_cnt and acc1_cnt SHALL count lane accepts; all counters SHALL saturate at all-ones.
REQ-028 Macro FEEDER_STATS_EN undefined: the counter logic SHALL be absent and the three counter outputs SHALL be tied to 0.

Structure
REQ-029 A shared package feeder_pkg SHALL hold the lane_state_e typedef (EMPTY, HELD) and the default DWIDTH and CNT_WIDTH constants.
REQ-030 One sub-module, feeder_lane_reg, SHALL implement a single lane's holding register and ready logic, instantiated twice.

Verification
REQ-031 Single lane: s0 sends 0xA1 with fifo_in_valid=1 -> next cycle inA_enque_en=1, inA_data=0xA1, inB_enque_en=0.
REQ-032 Ordering: s1 sends 0xB1 at t0 and s0 sends 0xA2 at t1 with fifo_in_valid=0 until t3 -> at t3 inA=0xB1 and inB=0xA2, both enables 1.
REQ-033 Same-cycle tie: s0=0x11 and s1=0x22 together, FIFO open -> inA=0x11, inB=0x22.
REQ-034 Backpressure: both lanes HELD and fifo_in_valid=0 for 5 cycles -> s0_ready=s1_ready=0, data retained, stall_cnt=5 with FEEDER_STATS_EN.
REQ-035 Flush: flush with both lanes HELD plus a new s0_valid -> no enables, s0_ready=0, both lanes EMPTY next cycle.
REQ-036 Reset: rst mid-stream with words HELD -> all outputs 0, and after release the first accept yields one strobe with the new data.
